// File: rtl/branch_flag_unit_if.sv
// Execute-to-fetch link of the branch/flag unit: ALU flag writes and branch
// requests flow in, the flag register, PC redirect and halt status flow out.
// Handshake: each *_valid is a single-cycle qualifier sampled at posedge clk;
// there is no ready, as the unit accepts or deliberately ignores (wrong-path
// or halted) every presented op in the cycle it appears.
interface branch_flag_unit_if #(
  parameter int PC_W  = 16,
  parameter int IMM_W = 9
);
  logic             alu_valid;
  logic [3:0]       alu_opcode;
  logic [2:0]       alu_flags;
  logic             br_valid;
  logic             br_is_reg;
  logic [2:0]       br_ccc;
  logic [IMM_W-1:0] br_imm;
  logic [PC_W-1:0]  br_rs;
  logic [PC_W-1:0]  pc_plus2;
  logic             hlt_valid;
  logic [2:0]       flags;
  logic             redirect;
  logic [PC_W-1:0]  redirect_pc;
  logic             flush;
  logic             halted;
  logic [1:0]       state;

  modport master (
    output alu_valid, alu_opcode, alu_flags, br_valid, br_is_reg, br_ccc,
           br_imm, br_rs, pc_plus2, hlt_valid,
    input  flags, redirect, redirect_pc, flush, halted, state
  );

  modport slave (
    input  alu_valid, alu_opcode, alu_flags, br_valid, br_is_reg, br_ccc,
           br_imm, br_rs, pc_plus2, hlt_valid,
    output flags, redirect, redirect_pc, flush, halted, state
  );
endinterface

// File: rtl/branch_flag_unit.sv
// Architectural V/N/Z flag register, branch condition evaluation with
// same-cycle flag forwarding, registered PC redirect/flush, and HLT tracking.
module branch_flag_unit #(
  parameter int PC_W  = 16,
  parameter int IMM_W = 9
) (
  input logic                clk,
  input logic                rst,
  branch_flag_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SHADOW = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t          state_q;
  logic [2:0]      flags_q;
  logic            redirect_q;
  logic [PC_W-1:0] redirect_pc_q;
  logic            halted_q;

  logic            wr_vnz;
  logic            wr_z;
  logic [2:0]      flags_nxt;
  logic            cond_ok;
  logic            taken;
  logic [PC_W-1:0] imm_sext;
  logic [PC_W-1:0] target;

  // Which flag bits the completing ALU op writes (arith: all, logic/shift: Z)
  always_comb begin
    wr_vnz = 1'b0;
    wr_z   = 1'b0;
    if (bus.alu_valid) begin
      case (bus.alu_opcode)
        4'b0000, 4'b0001:                   begin wr_vnz = 1'b1; wr_z = 1'b1; end
        4'b0010, 4'b0100, 4'b0101, 4'b0110: wr_z = 1'b1;
        default: ;
      endcase
    end
  end

  // Post-write flag value; doubles as the forwarded flags seen by a branch
  assign flags_nxt = {wr_vnz ? bus.alu_flags[2] : flags_q[2],
                      wr_vnz ? bus.alu_flags[1] : flags_q[1],
                      wr_z   ? bus.alu_flags[0] : flags_q[0]};

  // Condition evaluation against the effective {V,N,Z}
  always_comb begin
    cond_ok = 1'b0;
    case (bus.br_ccc)
      3'b000: cond_ok = ~flags_nxt[0];
      3'b001: cond_ok = flags_nxt[0];
      3'b010: cond_ok = ~flags_nxt[0] & ~flags_nxt[1];
      3'b011: cond_ok = flags_nxt[1];
      3'b100: cond_ok = flags_nxt[0] | ~flags_nxt[1];
      3'b101: cond_ok = flags_nxt[1] | flags_nxt[0];
      3'b110: cond_ok = flags_nxt[2];
      default: cond_ok = 1'b1;
    endcase
  end

  // Branch target: word offset scaled to bytes, wraps silently at 2^PC_W
  assign imm_sext = {{(PC_W-IMM_W){bus.br_imm[IMM_W-1]}}, bus.br_imm};
  assign target   = bus.br_is_reg ? bus.br_rs
                                  : bus.pc_plus2 + {imm_sext[PC_W-2:0], 1'b0};

  // HLT outranks a simultaneous branch since both cannot be on the real path
  assign taken = bus.br_valid & cond_ok & ~bus.hlt_valid;

  // Control FSM with registered flag, redirect and halt outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      flags_q       <= 3'b000;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      halted_q      <= 1'b0;
    end else begin
      redirect_q <= 1'b0;
      case (state_q)
        RUN: begin
          flags_q <= flags_nxt;
          if (bus.hlt_valid) begin
            state_q  <= HALTED;
            halted_q <= 1'b1;
          end else if (taken) begin
            state_q       <= SHADOW;
            redirect_q    <= 1'b1;
            redirect_pc_q <= target;
          end
        end
        SHADOW: begin
          // Older ALU op still retires; branch/HLT here are wrong-path
          flags_q <= flags_nxt;
          state_q <= RUN;
        end
        HALTED: begin
          halted_q <= 1'b1;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign bus.flags       = flags_q;
  assign bus.redirect    = redirect_q;
  assign bus.flush       = redirect_q;
  assign bus.redirect_pc = redirect_pc_q;
  assign bus.halted      = halted_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_branch_flag_unit.sv
// Directed bench for branch_flag_unit: flag masking, forwarding, condition
// table, target wrap, shadow squash, back-to-back branches, reset and halt.
module tb_branch_flag_unit;

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_SHADOW = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  branch_flag_unit_if #(.PC_W(16), .IMM_W(9)) bf ();

  branch_flag_unit #(.PC_W(16), .IMM_W(9)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bf)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bf.alu_valid  = 1'b0;
    bf.alu_opcode = 4'h0;
    bf.alu_flags  = 3'b000;
    bf.br_valid   = 1'b0;
    bf.br_is_reg  = 1'b0;
    bf.br_ccc     = 3'b000;
    bf.br_imm     = '0;
    bf.br_rs      = '0;
    bf.pc_plus2   = '0;
    bf.hlt_valid  = 1'b0;
  endtask

  task automatic drive_alu(input logic [3:0] op, input logic [2:0] f);
    bf.alu_valid  = 1'b1;
    bf.alu_opcode = op;
    bf.alu_flags  = f;
  endtask

  task automatic drive_b(input logic [2:0] ccc, input logic [8:0] imm, input logic [15:0] pc2);
    bf.br_valid  = 1'b1;
    bf.br_is_reg = 1'b0;
    bf.br_ccc    = ccc;
    bf.br_imm    = imm;
    bf.pc_plus2  = pc2;
  endtask

  task automatic drive_br(input logic [2:0] ccc, input logic [15:0] rs);
    bf.br_valid  = 1'b1;
    bf.br_is_reg = 1'b1;
    bf.br_ccc    = ccc;
    bf.br_rs     = rs;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bf.alu_valid  = 1'($urandom_range(0, 1));
      bf.alu_opcode = 4'($urandom_range(0, 15));
      bf.alu_flags  = 3'($urandom_range(0, 7));
      bf.br_valid   = 1'($urandom_range(0, 1));
      bf.br_is_reg  = 1'($urandom_range(0, 1));
      bf.br_ccc     = 3'($urandom_range(0, 7));
      bf.br_imm     = 9'($urandom_range(0, 511));
      bf.br_rs      = 16'($urandom_range(0, 65535));
      bf.pc_plus2   = 16'($urandom_range(0, 65535));
      bf.hlt_valid  = 1'($urandom_range(0, 1));
      tick();
    end
    rst = 1'b0;
    idle();
    total++; if (bf.flags !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", bf.flags); end
    total++; if (bf.redirect !== 1'b0) begin bad++; $display("FAIL reset_redirect got=%b exp=0", bf.redirect); end
    total++; if (bf.flush !== 1'b0) begin bad++; $display("FAIL reset_flush got=%b exp=0", bf.flush); end
    total++; if (bf.halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", bf.halted); end
    total++; if (bf.redirect_pc !== 16'h0000) begin bad++; $display("FAIL reset_pc got=%h exp=0000", bf.redirect_pc); end
    total++; if (bf.state !== S_RUN) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", bf.state, S_RUN); end
  endtask

  task automatic test_flag_mask();
    drive_alu(4'b0000, 3'b110); tick(); idle();
    total++; if (bf.flags !== 3'b110) begin bad++; $display("FAIL mask_add got=%b exp=110", bf.flags); end
    drive_alu(4'b0010, 3'b001); tick(); idle();
    total++; if (bf.flags !== 3'b111) begin bad++; $display("FAIL mask_xor got=%b exp=111", bf.flags); end
    drive_alu(4'b0011, 3'b000); tick(); idle();
    total++; if (bf.flags !== 3'b111) begin bad++; $display("FAIL mask_nowrite got=%b exp=111", bf.flags); end
    drive_alu(4'b0110, 3'b000); tick(); idle();
    total++; if (bf.flags !== 3'b110) begin bad++; $display("FAIL mask_ror got=%b exp=110", bf.flags); end
    // SUB with only V set: N and Z must also be overwritten
    drive_alu(4'b0001, 3'b100); tick(); idle();
    total++; if (bf.flags !== 3'b100) begin bad++; $display("FAIL mask_sub got=%b exp=100", bf.flags); end
  endtask

  task automatic test_fwd_eq();
    // Register holds Z=0; only the forwarded SUB result makes EQ true
    drive_alu(4'b0001, 3'b001);
    drive_b(3'b001, 9'h1FE, 16'h0010);
    tick(); idle();
    total++; if (bf.redirect !== 1'b1) begin bad++; $display("FAIL fwd_redirect got=%b exp=1", bf.redirect); end
    total++; if (bf.flush !== 1'b1) begin bad++; $display("FAIL fwd_flush got=%b exp=1", bf.flush); end
    total++; if (bf.redirect_pc !== 16'h000C) begin bad++; $display("FAIL fwd_pc got=%h exp=000c", bf.redirect_pc); end
    total++; if (bf.flags !== 3'b001) begin bad++; $display("FAIL fwd_flags got=%b exp=001", bf.flags); end
    total++; if (bf.state !== S_SHADOW) begin bad++; $display("FAIL fwd_state got=%0d exp=%0d", bf.state, S_SHADOW); end
    tick();
    total++; if (bf.redirect !== 1'b0) begin bad++; $display("FAIL fwd_pulse_len got=%b exp=0", bf.redirect); end
    total++; if (bf.redirect_pc !== 16'h000C) begin bad++; $display("FAIL fwd_pc_hold got=%h exp=000c", bf.redirect_pc); end
    // XOR forwards Z=0 while held N/V come from the register (001 -> 000): NE taken
    drive_alu(4'b0010, 3'b000);
    drive_br(3'b000, 16'h2222);
    tick(); idle();
    total++; if (bf.redirect !== 1'b1) begin bad++; $display("FAIL fwd_ne got=%b exp=1", bf.redirect); end
    tick();
  endtask

  task automatic test_not_taken_wrap();
    drive_alu(4'b0000, 3'b000); tick(); idle();
    drive_b(3'b011, 9'h004, 16'h0200); tick(); idle();
    total++; if (bf.redirect !== 1'b0) begin bad++; $display("FAIL nt_lt got=%b exp=0", bf.redirect); end
    total++; if (bf.state !== S_RUN) begin bad++; $display("FAIL nt_state got=%0d exp=%0d", bf.state, S_RUN); end
    drive_b(3'b111, 9'h0FF, 16'hFF00); tick(); idle();
    total++; if (bf.redirect !== 1'b1) begin bad++; $display("FAIL wrap_redirect got=%b exp=1", bf.redirect); end
    total++; if (bf.redirect_pc !== 16'h00FE) begin bad++; $display("FAIL wrap_pc got=%h exp=00fe", bf.redirect_pc); end
    tick();
  endtask

  task automatic test_cond_table();
    logic [2:0]  fl   [3];
    logic [7:0]  mask [3];
    fl[0] = 3'b010; mask[0] = 8'b1010_1001;
    fl[1] = 3'b101; mask[1] = 8'b1111_0010;
    fl[2] = 3'b000; mask[2] = 8'b1001_0101;
    for (int k = 0; k < 3; k++) begin
      drive_alu(4'b0000, fl[k]); tick(); idle();
      for (int c = 0; c < 8; c++) begin
        drive_br(3'(c), 16'h1235 + 16'(c));
        tick(); idle();
        total++;
        if (bf.redirect !== mask[k][c]) begin
          bad++; $display("FAIL cond f=%b ccc=%0d got=%b exp=%b", fl[k], c, bf.redirect, mask[k][c]);
        end
        if (mask[k][c]) begin
          total++;
          if (bf.redirect_pc !== 16'h1235 + 16'(c)) begin
            bad++; $display("FAIL cond_pc ccc=%0d got=%h exp=%h", c, bf.redirect_pc, 16'h1235 + 16'(c));
          end
          tick();
        end
      end
    end
  endtask

  task automatic test_shadow_squash();
    drive_br(3'b111, 16'h1234); tick(); idle();
    total++; if (bf.redirect !== 1'b1) begin bad++; $display("FAIL sh_redirect got=%b exp=1", bf.redirect); end
    total++; if (bf.redirect_pc !== 16'h1234) begin bad++; $display("FAIL sh_pc got=%h exp=1234", bf.redirect_pc); end
    drive_br(3'b111, 16'h5678);
    drive_alu(4'b0000, 3'b010);
    bf.hlt_valid = 1'b1;
    tick(); idle();
    total++; if (bf.redirect !== 1'b0) begin bad++; $display("FAIL sh_squash got=%b exp=0", bf.redirect); end
    total++; if (bf.redirect_pc !== 16'h1234) begin bad++; $display("FAIL sh_pc_hold got=%h exp=1234", bf.redirect_pc); end
    total++; if (bf.flags !== 3'b010) begin bad++; $display("FAIL sh_flags got=%b exp=010", bf.flags); end
    total++; if (bf.halted !== 1'b0) begin bad++; $display("FAIL sh_hlt_ignored got=%b exp=0", bf.halted); end
    total++; if (bf.state !== S_RUN) begin bad++; $display("FAIL sh_state got=%0d exp=%0d", bf.state, S_RUN); end
  endtask

  task automatic test_back_to_back();
    // Directly follows SHADOW: first RUN cycle accepts a new branch
    drive_b(3'b111, 9'h002, 16'h0100); tick(); idle();
    total++; if (bf.redirect !== 1'b1) begin bad++; $display("FAIL b2b_redirect got=%b exp=1", bf.redirect); end
    total++; if (bf.redirect_pc !== 16'h0104) begin bad++; $display("FAIL b2b_pc got=%h exp=0104", bf.redirect_pc); end
    tick();
    total++; if (bf.redirect !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b exp=0", bf.redirect); end
  endtask

  task automatic test_reset_in_shadow();
    drive_br(3'b111, 16'hBEEF); tick(); idle();
    total++; if (bf.state !== S_SHADOW) begin bad++; $display("FAIL rsh_state got=%0d exp=%0d", bf.state, S_SHADOW); end
    rst = 1'b1;
    drive_br(3'b111, 16'hCAFE);
    drive_alu(4'b0000, 3'b111);
    tick(); idle(); rst = 1'b0;
    total++; if (bf.redirect !== 1'b0) begin bad++; $display("FAIL rsh_redirect got=%b exp=0", bf.redirect); end
    total++; if (bf.redirect_pc !== 16'h0000) begin bad++; $display("FAIL rsh_pc got=%h exp=0000", bf.redirect_pc); end
    total++; if (bf.flags !== 3'b000) begin bad++; $display("FAIL rsh_flags got=%b exp=000", bf.flags); end
    total++; if (bf.state !== S_RUN) begin bad++; $display("FAIL rsh_run got=%0d exp=%0d", bf.state, S_RUN); end
  endtask

  task automatic test_halt();
    drive_alu(4'b0000, 3'b110); tick(); idle();
    bf.hlt_valid = 1'b1;
    drive_br(3'b111, 16'h4444);
    drive_alu(4'b0000, 3'b001);
    tick(); idle();
    total++; if (bf.halted !== 1'b1) begin bad++; $display("FAIL hlt_halted got=%b exp=1", bf.halted); end
    total++; if (bf.redirect !== 1'b0) begin bad++; $display("FAIL hlt_redirect got=%b exp=0", bf.redirect); end
    total++; if (bf.flags !== 3'b001) begin bad++; $display("FAIL hlt_flag_write got=%b exp=001", bf.flags); end
    total++; if (bf.state !== S_HALTED) begin bad++; $display("FAIL hlt_state got=%0d exp=%0d", bf.state, S_HALTED); end
    drive_alu(4'b0000, 3'b110);
    drive_br(3'b111, 16'h5555);
    tick(); idle();
    total++; if (bf.flags !== 3'b001) begin bad++; $display("FAIL hlt_freeze got=%b exp=001", bf.flags); end
    total++; if (bf.redirect !== 1'b0) begin bad++; $display("FAIL hlt_no_br got=%b exp=0", bf.redirect); end
    total++; if (bf.halted !== 1'b1) begin bad++; $display("FAIL hlt_stay got=%b exp=1", bf.halted); end
    rst = 1'b1; tick(); rst = 1'b0;
    total++; if (bf.halted !== 1'b0) begin bad++; $display("FAIL hlt_reset got=%b exp=0", bf.halted); end
    total++; if (bf.state !== S_RUN) begin bad++; $display("FAIL hlt_reset_state got=%0d exp=%0d", bf.state, S_RUN); end
  endtask

  // Sequencer
  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    idle();
    test_reset();
    test_flag_mask();
    test_fwd_eq();
    test_not_taken_wrap();
    test_cond_table();
    test_shadow_squash();
    test_back_to_back();
    test_reset_in_shadow();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_flag_unit.md
Name: branch_flag_unit

Overview:
- Consumer end of the ALU flag interface. Holds the architectural V/N/Z flag register, written per opcode from ALU results.
- Evaluates B/BR conditions against those flags, with same-cycle forwarding, and issues a registered PC redirect/flush to fetch.
- Tracks HLT. Sits between the execute stage (ALU) and the PC/fetch logic of the 16-bit CPU.

Parameters:
- PC_W, 16, width of PC, branch target and register operand
- IMM_W, 9, width of the B-type signed word offset

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- alu_valid  input  1  an ALU op completes this cycle
- alu_opcode  input  4  opcode of the completing ALU op
- alu_flags  input  3  ALU flags: [2]=V, [1]=N, [0]=Z
- br_valid  input  1  branch instruction presented this cycle
- br_is_reg  input  1  0=B (PC-relative), 1=BR (register target)
- br_ccc  input  3  condition code
- br_imm  input  IMM_W  signed word offset (B)
- br_rs  input  PC_W  register target (BR)
- pc_plus2  input  PC_W  PC+2 of the branch instruction
- hlt_valid  input  1  HLT instruction presented
- flags  output  3  current flag register {V,N,Z}
- redirect  output  1  one-cycle pulse: load redirect_pc into PC
- redirect_pc  output  PC_W  branch target, valid while redirect=1
- flush  output  1  equals redirect; squash younger instructions
- halted  output  1  processor halted

Behaviour:
- Reset (sync, rst=1 at posedge): flags=3'b000, redirect=0, redirect_pc=0, flush=0, halted=0, FSM=RUN. rst overrides every other input in the same cycle.
- Flag write on alu_valid:
  - ADD 4'b0000 and SUB 4'b0001 write V, N and Z.
  - XOR 4'b0010, SLL 4'b0100, SRA 4'b0101 and ROR 4'b0110 write Z only; V and N hold.
  - All other opcodes write nothing.
  - The write takes effect at the next posedge.
- Forwarding: when br_valid and a flag-writing alu_valid occur in the same cycle, the condition uses the post-write flag value: the newly written bits, with held bits taken from the register.
- Conditions (f = effective flags):
  - 000 NE: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 and N=0
  - 011 LT: N=1
  - 100 GE: Z=1 or (Z=0 and N=0)
  - 101 LE: N=1 or Z=1
  - 110 OV: V=1
  - 111 always
- Target computation:
  - B: pc_plus2 + (sign_extend(br_imm) << 1), modulo 2^PC_W; wrap-around is silent.
  - BR: br_rs unchanged, with bit 0 passed through.
- Latency: a taken branch at cycle t gives redirect=flush=1 and redirect_pc=target at cycle t+1, for exactly one cycle. Not-taken gives no pulse. redirect_pc holds its last value when redirect=0.
- FSM states: RUN, SHADOW, HALTED.
  - RUN: taken branch -> SHADOW, with a pulse next cycle. hlt_valid -> HALTED.
  - SHADOW: lasts one cycle, the cycle in which redirect=1. br_valid and hlt_valid are ignored because they are wrong-path. alu_valid still updates flags because that op is older. Next state is RUN.
  - HALTED: halted=1; br_valid, hlt_valid and alu_valid are all ignored; flags freeze. Only rst exits.
- Simultaneous events:
  - hlt_valid and br_valid in RUN: HLT wins, because they cannot both be real. No redirect; go to HALTED.
  - alu_valid in the same cycle as hlt_valid: the flag write still occurs.
- Reset during SHADOW: the pending redirect is cancelled; outputs take reset values the next cycle.
- Back-to-back: a taken branch in the first cycle after SHADOW, now in RUN, is accepted normally.

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs -> flags=000, redirect=0, halted=0, redirect_pc=0.
- Flag masking: ADD with alu_flags=3'b110, then XOR with alu_flags=3'b001 -> flags=110 then 111.
- B forwarded EQ: SUB with alu_flags=001 and B ccc=001, imm=9'h1FE (-2), pc_plus2=16'h0010, all in the same cycle -> next cycle redirect=1, redirect_pc=16'h000C.
- Not taken and wrap: flags=000 with B ccc=011 -> no redirect. ccc=111, imm=9'h0FF, pc_plus2=16'hFF00 -> redirect_pc=16'h00FE.
- Shadow squash: BR ccc=111, rs=16'h1234 taken, followed next cycle by br_valid ccc=111 and an ADD -> one pulse with redirect_pc=16'h1234. The second branch is ignored and the ADD flags are applied.
- Halt: hlt_valid and br_valid ccc=111 together -> halted=1, no redirect, and later alu_valid leaves flags unchanged. rst -> halted=0.
